// File: rtl/mem_stage.sv
// miniRV MEM stage: issues loads/stores on a handshaked data bus through an
// IDLE/BUSY/DONE FSM and forms the write-back triple for the MEM/WB register.
module mem_stage (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        valid_MEM_in,
  input  logic        mem_rd_MEM_in,
  input  logic        mem_wr_MEM_in,
  input  logic [2:0]  mem_op_MEM_in,
  input  logic [31:0] alu_c_MEM_in,
  input  logic [31:0] rD2_MEM_in,
  input  logic [31:0] pc4_MEM_in,
  input  logic [31:0] ext_MEM_in,
  input  logic [1:0]  wd_sel_MEM_in,
  input  logic [4:0]  wR_MEM_in,
  input  logic        rf_we_MEM_in,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  wR_MEM_out,
  output logic        rf_we_MEM_out,
  output logic [31:0] wD_MEM_out,
  output logic        mem_stall,
  output logic        misalign_MEM_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg;
  logic [31:0] rdata_reg;
  logic        access;
  logic        aligned;
  logic        start;
  logic [31:0] wdata_next;
  logic [3:0]  wstrb_next;
  logic [7:0]  rbyte [4];
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] load_data;

  assign access = valid_MEM_in & (mem_rd_MEM_in | mem_wr_MEM_in);

  always_comb begin
    aligned = 1'b1;
    case (mem_op_MEM_in[1:0])
      2'b10:   aligned = (alu_c_MEM_in[1:0] == 2'b00);
      2'b01:   aligned = ~alu_c_MEM_in[0];
      default: aligned = 1'b1;
    endcase
  end

  assign start = access & aligned & (state_reg == IDLE);

  // Store data is replicated across lanes so the strobes alone pick the bytes.
  always_comb begin
    wdata_next = rD2_MEM_in;
    wstrb_next = 4'b1111;
    case (mem_op_MEM_in[1:0])
      2'b00: begin
        wdata_next = {4{rD2_MEM_in[7:0]}};
        wstrb_next = 4'b0001 << alu_c_MEM_in[1:0];
      end
      2'b01: begin
        wdata_next = {2{rD2_MEM_in[15:0]}};
        wstrb_next = alu_c_MEM_in[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!mem_wr_MEM_in) wstrb_next = 4'b0000;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg  <= IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_wdata <= 32'd0;
      dbus_wstrb <= 4'd0;
      rdata_reg  <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          state_reg  <= BUSY;
          dbus_req   <= 1'b1;
          dbus_we    <= mem_wr_MEM_in;
          dbus_addr  <= {alu_c_MEM_in[31:2], 2'b00};
          dbus_wdata <= wdata_next;
          dbus_wstrb <= wstrb_next;
        end
        BUSY: if (dbus_ack) begin
          rdata_reg <= dbus_rdata;
          dbus_req  <= 1'b0;
          state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = rdata_reg[8*gi +: 8];
    end
  endgenerate

  assign bsel = rbyte[alu_c_MEM_in[1:0]];
  assign hsel = alu_c_MEM_in[1] ? rdata_reg[31:16] : rdata_reg[15:0];

  always_comb begin
    case (mem_op_MEM_in)
      3'b000:  load_data = {{24{bsel[7]}}, bsel};
      3'b100:  load_data = {24'd0, bsel};
      3'b001:  load_data = {{16{hsel[15]}}, hsel};
      3'b101:  load_data = {16'd0, hsel};
      default: load_data = rdata_reg;
    endcase
  end

  always_comb begin
    case (wd_sel_MEM_in)
      2'b00:   wD_MEM_out = alu_c_MEM_in;
      2'b01:   wD_MEM_out = load_data;
      2'b10:   wD_MEM_out = pc4_MEM_in;
      default: wD_MEM_out = ext_MEM_in;
    endcase
  end

  assign mem_stall        = ~cpu_rst & (start | (state_reg == BUSY));
  assign misalign_MEM_out = ~cpu_rst & access & ~aligned;
  assign rf_we_MEM_out    = ~cpu_rst & rf_we_MEM_in & valid_MEM_in & ~mem_stall & ~misalign_MEM_out;
  assign wR_MEM_out       = wR_MEM_in;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access (MEM) stage of the miniRV five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It runs loads and stores on a handshaked data bus through a small FSM and stalls the pipeline while an access is in flight. It then produces the final write-back triple (`wR_MEM_out`, `rf_we_MEM_out`, `wD_MEM_out`) that the MEM/WB register captures.

## Interface
Parameters: none.

- `cpu_clk` in 1: single clock; all state updates on its rising edge.
- `cpu_rst` in 1: reset, **synchronous, active-high**.
- `valid_MEM_in` in 1: instruction in MEM is valid (0 = bubble).
- `mem_rd_MEM_in` in 1: instruction is a load.
- `mem_wr_MEM_in` in 1: instruction is a store.
- `mem_op_MEM_in` in 3: RV funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `alu_c_MEM_in` in 32: ALU result; the byte address for loads and stores.
- `rD2_MEM_in` in 32: store data.
- `pc4_MEM_in` in 32: PC+4.
- `ext_MEM_in` in 32: immediate.
- `wd_sel_MEM_in` in 2: write-back source (00 ALU, 01 load, 10 PC+4, 11 imm).
- `wR_MEM_in` in 5: destination register.
- `rf_we_MEM_in` in 1: register write enable.
- `dbus_req` out 1: bus request, registered.
- `dbus_we` out 1: 1 = write, registered.
- `dbus_addr` out 32: word address (`alu_c[31:2]`, 2'b00), registered.
- `dbus_wdata` out 32: lane-replicated store data, registered.
- `dbus_wstrb` out 4: byte strobes, registered.
- `dbus_ack` in 1: bus completion, one-cycle pulse.
- `dbus_rdata` in 32: read word, valid with `dbus_ack`.
- `wR_MEM_out` out 5: destination register to MEM/WB.
- `rf_we_MEM_out` out 1: write enable to MEM/WB.
- `wD_MEM_out` out 32: write-back data to MEM/WB.
- `mem_stall` out 1: hold all upstream registers and insert a bubble into MEM/WB.
- `misalign_MEM_out` out 1: one-cycle flag for a misaligned access.

## Operation
- An access is `valid & (mem_rd | mem_wr)`. It is aligned when: w needs `addr[1:0]=0`; h/hu need `addr[0]=0`; b/bu are always aligned.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on an aligned access. In the same edge, register the bus fields and set `dbus_req=1`.
  - BUSY: hold all `dbus_*` stable. On `dbus_ack`, capture `dbus_rdata` into `rdata_q`, clear `dbus_req`, and go to DONE.
  - DONE → IDLE unconditionally after one cycle.
- `mem_stall = (IDLE & aligned access) | BUSY`. It is 0 in DONE, which lets the pipeline advance past the completed instruction.
- Store lanes:
  - sb: `wdata={4{rD2[7:0]}}`, `wstrb=1<<addr[1:0]`.
  - sh: `wdata={2{rD2[15:0]}}`, `wstrb=addr[1]?1100:0011`.
  - sw: `wstrb=1111`.
  - Loads: `wstrb=0000`, `dbus_we=0`.
- Load extraction from `rdata_q`:
  - Byte select is `addr[1:0]`; halfword select is `addr[1]`.
  - b/h sign-extend; bu/hu zero-extend; w passes through unchanged.
- `wD_MEM_out` mux by `wd_sel`:
  - ALU selects `alu_c`.
  - Load selects the extracted `rdata_q`; it is meaningful only in DONE.
  - PC+4 selects `pc4`; imm selects `ext`.
- `rf_we_MEM_out` equals `rf_we_MEM_in & valid_MEM_in` with these overrides:
  - Forced 0 while `mem_stall=1`.
  - Forced 0 on a misaligned access.
- `wR_MEM_out` passes `wR_MEM_in` through.
- Misaligned access: no bus transaction and no stall. `misalign_MEM_out=1` for that cycle and `rf_we_MEM_out=0`.
- Non-memory instructions never enter BUSY and add zero latency.

## Timing
- Reset (sampled at the edge while `cpu_rst=1`):
  - State → IDLE.
  - `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_wdata`, `dbus_wstrb` and `rdata_q` → 0.
  - While `cpu_rst` is high, `mem_stall`, `rf_we_MEM_out` and `misalign_MEM_out` are forced to 0.
- Reset in BUSY or DONE aborts the access, drops `dbus_req` at that edge, and ignores any later `dbus_ack` until a new request is issued.
- Load with same-cycle ack (minimum latency), relative to cycle 0 when the load enters MEM:
  - Cycle 0: IDLE, stall=1.
  - Cycle 1: BUSY, req=1, ack=1.
  - Cycle 2: DONE, stall=0, `wD` valid.
- Each extra wait cycle before ack adds one cycle to the total.
- `dbus_ack` in IDLE or DONE is ignored.
- Back-to-back memory instructions: the second is seen in IDLE on the cycle after DONE. No request overlap occurs.

## Test plan
- **lw, aligned, ack on the first BUSY cycle.** Stimulus: `addr=0x100`, `rdata=0xDEADBEEF`. Required: stall high for cycles 0–1; `dbus_req` high in cycle 1 only; in cycle 2, `wD=0xDEADBEEF`, `rf_we=1`, stall=0.
- **Sign and zero extension.** Stimulus: `rdata=0x8070F0FF`. Required:
  - lb at `addr=…3` gives `0xFFFFFF80`.
  - lbu at `addr=…1` gives `0x000000F0`.
  - lh at `addr=…2` gives `0xFFFF8070`.
  - lhu at `addr=…0` gives `0x0000F0FF`.
- **sh at `addr=0x206`, `rD2=0x1234ABCD`.** Required: `dbus_addr=0x204`, `wdata=0xABCDABCD`, `wstrb=1100`, `we=1`. Ack after 3 wait cycles gives stall for 5 cycles total.
- **Misaligned lw at `addr=0x102`.** Required: no `dbus_req`; `misalign_MEM_out=1` for one cycle; `rf_we_MEM_out=0`; stall=0.
- **Reset in BUSY.** Stimulus: assert `cpu_rst` with `dbus_req=1`. Required: next cycle `dbus_req=0`, state IDLE, stall=0; a stray `dbus_ack` afterwards has no effect.
- **Non-memory instruction.** Stimulus: `wd_sel=10`, `pc4=0x44`. Required: `wD=0x44`, no stall, no bus activity.
